// File: rtl/rv_pipeline_defs.sv
// Shared definitions for the RV32IM pipeline front end:
// fetch FSM encodings, bubble instruction and IF/ID field widths.
package rv_pipeline_defs;

    localparam int XLEN        = 32;
    localparam int IF_ID_PC_W  = XLEN;
    localparam int IF_ID_INS_W = 32;

    localparam logic [XLEN-1:0]        RESET_VECTOR_C = 32'h0000_0000;
    localparam logic [IF_ID_INS_W-1:0] NOP_INSTR_C    = 32'h0000_0013;

    typedef enum logic {
        RUN           = 1'b0,
        HOLD_REDIRECT = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold or flush to a bubble.
// Reset and flush both leave the bubble {0, 4, NOP, invalid}.
module if_id_reg
    import rv_pipeline_defs::*;
#(
    parameter logic [IF_ID_INS_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   flush,
    input  logic [IF_ID_PC_W-1:0]  pc_in,
    input  logic [IF_ID_INS_W-1:0] instr_in,
    output logic [IF_ID_PC_W-1:0]  pc_out,
    output logic [IF_ID_PC_W-1:0]  pc4_out,
    output logic [IF_ID_INS_W-1:0] instr_out,
    output logic                   valid_out
);

    logic [IF_ID_PC_W-1:0]  pc_d, pc_q, pc4_d, pc4_q;
    logic [IF_ID_INS_W-1:0] instr_d, instr_q;
    logic                   valid_d, valid_q;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = '0;
            pc4_d   = 32'd4;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            pc4_d   = pc_in + 32'd4;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            pc4_q   <= 32'd4;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign pc4_out   = pc4_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, absorbs cache-miss stalls and EX redirects,
// parking a redirect that arrives mid-miss so the cache address stays put.
module fetch_unit
    import rv_pipeline_defs::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_C,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_C
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CACHE_BUSYWAIT,
    input  logic [31:0] INSTRUCTION_IN,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] CACHE_ADDR,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_INSTR,
    output logic        IF_ID_VALID,
    output logic        REDIRECT_PENDING,
    output logic [31:0] FETCH_COUNT
);

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  pend_d, pend_q;
    logic [31:0]  cnt_d, cnt_q;
    logic         load, flush;
    logic [31:0]  tgt;

    assign tgt = align_word(BRANCH_TARGET);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (BRANCH_TAKEN && !CACHE_BUSYWAIT) begin
                    pc_d  = tgt;
                    flush = 1'b1;
                end else if (BRANCH_TAKEN) begin
                    pend_d  = tgt;
                    state_d = HOLD_REDIRECT;
                    flush   = 1'b1;
                end else if (STALL) begin
                    pc_d = pc_q;
                end else if (CACHE_BUSYWAIT) begin
                    flush = 1'b1;
                end else begin
                    load  = 1'b1;
                    pc_d  = pc_q + 32'd4;
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HOLD_REDIRECT: begin
                // Newest redirect wins, even on the edge the miss ends.
                flush = 1'b1;
                if (BRANCH_TAKEN)
                    pend_d = tgt;
                if (!CACHE_BUSYWAIT) begin
                    pc_d    = BRANCH_TAKEN ? tgt : pend_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk       (CLK),
        .reset     (RESET),
        .load      (load),
        .flush     (flush),
        .pc_in     (pc_q),
        .instr_in  (INSTRUCTION_IN),
        .pc_out    (IF_ID_PC),
        .pc4_out   (IF_ID_PC4),
        .instr_out (IF_ID_INSTR),
        .valid_out (IF_ID_VALID)
    );

    assign CACHE_ADDR       = pc_q;
    assign REDIRECT_PENDING = (state_q == HOLD_REDIRECT);
    assign FETCH_COUNT      = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random bench for fetch_unit against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CACHE_BUSYWAIT = 1'b0;
    logic [31:0] INSTRUCTION_IN;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic [31:0] CACHE_ADDR, IF_ID_PC, IF_ID_PC4, IF_ID_INSTR, FETCH_COUNT;
    logic        IF_ID_VALID, REDIRECT_PENDING;

    int total = 0;
    int bad = 0;
    bit fixed_mem = 1'b1;

    // Reference state: what the stage should look like after each edge.
    logic [31:0] m_pc, m_tgt, m_cnt, m_ifpc, m_ifins;
    bit          m_pend, m_valid;
    bit          saw_80;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return fixed_mem ? 32'h00A0_0093 : {a[15:0], ~a[31:16]};
    endfunction

    assign INSTRUCTION_IN = mem(CACHE_ADDR);

    fetch_unit dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .CACHE_BUSYWAIT   (CACHE_BUSYWAIT),
        .INSTRUCTION_IN   (INSTRUCTION_IN),
        .STALL            (STALL),
        .BRANCH_TAKEN     (BRANCH_TAKEN),
        .BRANCH_TARGET    (BRANCH_TARGET),
        .CACHE_ADDR       (CACHE_ADDR),
        .IF_ID_PC         (IF_ID_PC),
        .IF_ID_PC4        (IF_ID_PC4),
        .IF_ID_INSTR      (IF_ID_INSTR),
        .IF_ID_VALID      (IF_ID_VALID),
        .REDIRECT_PENDING (REDIRECT_PENDING),
        .FETCH_COUNT      (FETCH_COUNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_cnt = 0; m_pend = 0;
        m_ifpc = 0; m_ifins = 32'h13; m_valid = 0;
    endtask

    task automatic m_bubble();
        m_ifpc = 0; m_ifins = 32'h13; m_valid = 0;
    endtask

    task automatic m_step(input bit bt, input logic [31:0] t,
                          input bit bw, input bit st);
        logic [31:0] at;
        at = {t[31:2], 2'b00};
        if (m_pend) begin
            if (bt) m_tgt = at;
            if (!bw) begin
                m_pc = m_tgt;
                m_pend = 0;
            end
            m_bubble();
        end else if (bt) begin
            if (!bw) m_pc = at;
            else begin
                m_tgt = at;
                m_pend = 1;
            end
            m_bubble();
        end else if (st) begin
            m_valid = m_valid;
        end else if (bw) begin
            m_bubble();
        end else begin
            m_ifpc = m_pc; m_ifins = mem(m_pc); m_valid = 1;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all();
        chk("addr", CACHE_ADDR, m_pc);
        chk("valid", {31'b0, IF_ID_VALID}, {31'b0, m_valid});
        chk("instr", IF_ID_INSTR, m_ifins);
        chk("pending", {31'b0, REDIRECT_PENDING}, {31'b0, m_pend});
        chk("count", FETCH_COUNT, m_cnt);
        if (m_valid) begin
            chk("ifpc", IF_ID_PC, m_ifpc);
            chk("ifpc4", IF_ID_PC4, m_ifpc + 32'd4);
        end
        if (IF_ID_VALID === 1'b1 && IF_ID_PC === 32'h80) saw_80 = 1;
    endtask

    // Drive inputs at negedge, step model at posedge, check at next negedge.
    task automatic cyc(input bit bt, input logic [31:0] t,
                       input bit bw, input bit st);
        BRANCH_TAKEN = bt; BRANCH_TARGET = t;
        CACHE_BUSYWAIT = bw; STALL = st;
        @(posedge CLK);
        m_step(bt, t, bw, st);
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        m_reset();
        saw_80 = 0;
        repeat (2) @(negedge CLK);
        chk("rst_addr", CACHE_ADDR, 32'h0);
        chk("rst_pc", IF_ID_PC, 32'h0);
        chk("rst_pc4", IF_ID_PC4, 32'h4);
        chk("rst_instr", IF_ID_INSTR, 32'h13);
        chk("rst_valid", {31'b0, IF_ID_VALID}, 32'h0);
        chk("rst_cnt", FETCH_COUNT, 32'h0);
        RESET = 1'b0;

        // Straight-line hits
        cyc(0, 0, 0, 0);
        chk("hit_addr1", CACHE_ADDR, 32'h4);
        chk("hit_ifpc1", IF_ID_PC, 32'h0);
        cyc(0, 0, 0, 0);
        chk("hit_addr2", CACHE_ADDR, 32'h8);
        chk("hit_ifpc2", IF_ID_PC, 32'h4);
        cyc(0, 0, 0, 0);
        chk("hit_cnt3", FETCH_COUNT, 32'd3);
        chk("hit_instr", IF_ID_INSTR, 32'h00A0_0093);
        fixed_mem = 0;

        // Miss of 4 cycles at 0x40
        cyc(1, 32'h40, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0);
            chk("miss_addr", CACHE_ADDR, 32'h40);
            chk("miss_valid", {31'b0, IF_ID_VALID}, 32'h0);
        end
        cyc(0, 0, 0, 0);
        chk("miss_end_ifpc", IF_ID_PC, 32'h40);
        chk("miss_end_addr", CACHE_ADDR, 32'h44);

        // Redirect while hitting, low bits ignored
        cyc(1, 32'h103, 0, 0);
        chk("br_addr", CACHE_ADDR, 32'h100);
        chk("br_instr", IF_ID_INSTR, 32'h13);
        cyc(0, 0, 0, 0);
        chk("br_ifpc", IF_ID_PC, 32'h100);

        // Redirects parked during a miss; newest wins
        cyc(1, 32'h80, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 32'h200, 1, 0);
        chk("park_addr", CACHE_ADDR, 32'h80);
        chk("park_pend", {31'b0, REDIRECT_PENDING}, 32'h1);
        cyc(0, 0, 1, 1);
        cyc(1, 32'h300, 1, 0);
        cyc(0, 0, 1, 0);
        chk("park_addr2", CACHE_ADDR, 32'h80);
        cyc(0, 0, 0, 0);
        chk("unpark_addr", CACHE_ADDR, 32'h300);
        chk("unpark_pend", {31'b0, REDIRECT_PENDING}, 32'h0);
        cyc(0, 0, 0, 0);
        chk("unpark_ifpc", IF_ID_PC, 32'h300);
        chk("no_80", {31'b0, saw_80}, 32'h0);

        // Stall holds everything, redirect still wins
        cyc(1, 32'h1C, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, i[0], 1);
            chk("stall_ifpc", IF_ID_PC, 32'h1C);
            chk("stall_addr", CACHE_ADDR, 32'h20);
            chk("stall_cnt", FETCH_COUNT, m_cnt);
        end
        cyc(1, 32'h500, 0, 1);
        chk("stall_br_addr", CACHE_ADDR, 32'h500);
        chk("stall_br_valid", {31'b0, IF_ID_VALID}, 32'h0);

        // PC wrap
        cyc(1, 32'hFFFF_FFFC, 0, 0);
        cyc(0, 0, 0, 0);
        chk("wrap_pc4", IF_ID_PC4, 32'h0);
        chk("wrap_addr", CACHE_ADDR, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) == 0, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset in the middle of a parked redirect
        cyc(1, 32'h700, 0, 0);
        cyc(1, 32'h900, 1, 0);
        BRANCH_TAKEN = 0;
        #1 RESET = 1'b1;
        #1;
        m_reset();
        chk("async_addr", CACHE_ADDR, 32'h0);
        chk("async_pend", {31'b0, REDIRECT_PENDING}, 32'h0);
        chk("async_valid", {31'b0, IF_ID_VALID}, 32'h0);
        chk("async_cnt", FETCH_COUNT, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        CACHE_BUSYWAIT = 0;
        cyc(0, 0, 0, 0);
        chk("post_rst_ifpc", IF_ID_PC, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage of the RV32IM 5-stage pipeline. It sits directly upstream of the instruction cache.
- Owns the PC. Drives the cache address. Absorbs cache-miss stalls and branch/jump redirects from EX. Produces the IF/ID pipeline register consumed by decode.
- The cache address must never change while the cache reports BUSYWAIT. A redirect that arrives during a miss is therefore parked and applied once the miss completes.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID.

Ports:
- CLK  in  1  pipeline clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high.
- CACHE_BUSYWAIT  in  1  instruction cache miss in progress.
- INSTRUCTION_IN  in  32  instruction word returned by the cache for CACHE_ADDR.
- STALL  in  1  hazard-unit hold of IF and IF/ID (load-use).
- BRANCH_TAKEN  in  1  EX-stage redirect request, single-cycle pulse.
- BRANCH_TARGET  in  32  redirect address; bits [1:0] are ignored and treated as 0.
- CACHE_ADDR  out  32  equals PC; fed combinationally to the cache ADDR input.
- IF_ID_PC  out  32  PC of the instruction held in IF/ID.
- IF_ID_PC4  out  32  IF_ID_PC + 4, modulo 2^32.
- IF_ID_INSTR  out  32  instruction held in IF/ID.
- IF_ID_VALID  out  1  1 = real instruction; 0 = bubble.
- REDIRECT_PENDING  out  1  a redirect is parked while waiting for a miss to end.
- FETCH_COUNT  out  32  number of valid instructions delivered to IF/ID; wraps at 2^32.

Behaviour:
- Reset (asynchronous):
  - PC=RESET_VECTOR, state=RUN, pending target=0.
  - IF_ID_INSTR=NOP_INSTR, IF_ID_VALID=0, IF_ID_PC=0, IF_ID_PC4=4.
  - REDIRECT_PENDING=0, FETCH_COUNT=0.
  - Reset asserted mid-miss or mid-pending discards everything and returns to the values above.
- FSM, 2 states: RUN and HOLD_REDIRECT. Encodings are shared constants.
- RUN, evaluated at posedge in this priority order:
  1. BRANCH_TAKEN and CACHE_BUSYWAIT=0:
     - PC <= {BRANCH_TARGET[31:2],2'b00}.
     - IF/ID <= bubble (flush), regardless of STALL.
  2. BRANCH_TAKEN and CACHE_BUSYWAIT=1:
     - Latch the aligned target and go to HOLD_REDIRECT.
     - PC is unchanged. IF/ID <= bubble.
  3. STALL=1: PC and IF/ID hold, whatever the state of CACHE_BUSYWAIT.
  4. CACHE_BUSYWAIT=1: PC holds; IF/ID <= bubble.
  5. Otherwise:
     - IF/ID <= {PC, PC+4, INSTRUCTION_IN, valid=1}.
     - PC <= PC+4. FETCH_COUNT increments.
- HOLD_REDIRECT:
  - REDIRECT_PENDING=1. PC is held constant so the cache miss completes on the old address. IF/ID is held as a bubble.
  - On the first posedge with CACHE_BUSYWAIT=0:
    - PC <= parked target. State <= RUN.
    - The instruction returned for the old PC is discarded.
  - A further BRANCH_TAKEN while in HOLD_REDIRECT overwrites the parked target; the newest redirect wins.
  - STALL is ignored in this state.
- CACHE_ADDR is combinational from the PC register, with no added latency. A hit delivers 1 instruction per cycle into IF/ID.
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
- FETCH_COUNT increments only on rule 5.

Decomposition:
- Shared package/header (rv_pipeline_defs):
  - FSM state encodings RUN=1'b0, HOLD_REDIRECT=1'b1.
  - NOP_INSTR constant and RESET_VECTOR default.
  - IF/ID field widths.
- One sub-module is natural: if_id_reg. It holds PC, PC4, INSTR and VALID, with load, hold and flush controls and an asynchronous reset to the bubble value.
- PC register, pending register, FSM and counter stay in fetch_unit.

Test Plan:
- Reset release, cache always hits returning 32'h00A00093:
  - Over 3 cycles CACHE_ADDR = 0, 4, 8.
  - IF_ID_PC = 0 then 4, IF_ID_VALID=1, FETCH_COUNT=3.
- CACHE_BUSYWAIT high for 4 cycles at PC=32'h40:
  - CACHE_ADDR stays 32'h40 throughout and IF_ID_VALID=0.
  - The cycle after BUSYWAIT drops, IF/ID holds PC 32'h40 and CACHE_ADDR=32'h44.
- BRANCH_TAKEN with target 32'h0000_0103 while hitting:
  - Next CACHE_ADDR=32'h100 and IF/ID is a bubble (NOP, valid 0).
  - Following cycle IF_ID_PC=32'h100.
- BRANCH_TAKEN to 32'h200 during a miss at 32'h80, then a second BRANCH_TAKEN to 32'h300 before the miss ends:
  - CACHE_ADDR stays 32'h80 and REDIRECT_PENDING=1.
  - After BUSYWAIT drops: CACHE_ADDR=32'h300, REDIRECT_PENDING=0, and no instruction from 32'h80 ever appears valid.
- STALL high for 2 cycles at PC=32'h20 with IF/ID holding 32'h1C:
  - Both registers are unchanged and FETCH_COUNT is unchanged.
  - BRANCH_TAKEN during STALL (no miss) still redirects and flushes.
- PC=32'hFFFF_FFFC hit:
  - IF_ID_PC4=0 and next CACHE_ADDR=0.
  - Asserting RESET mid-miss returns CACHE_ADDR to RESET_VECTOR immediately, with no clock edge required.
